// File: rtl/mult_accumulator_if.sv
// ============================================================================
//  Module   : mult_accumulator_if
//  Purpose  : Product-in / result-out handshake bundle for mult_accumulator.
//             slave  = accumulator view, master = producer/consumer view.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_accumulator_if #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_overflow
  );

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_overflow
  );
endinterface

`default_nettype wire

// File: rtl/mult_accumulator.sv
// ============================================================================
//  Module   : mult_accumulator
//  Purpose  : Accumulates a run of unsigned multiplier products and presents
//             sum, term count and sticky overflow on an output handshake.
//  Options  : `define SATURATE_EN -> accumulator clamps at all-ones on carry
//             out instead of wrapping modulo 2^ACC_W.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_accumulator #(
  parameter int PROD_W    = 32,
  parameter int ACC_W     = 40,
  parameter int CNT_W     = 8,
  parameter int MAX_TERMS = 255
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           clr,
  mult_accumulator_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             xfer_d;
  logic [ACC_W:0]   sum_d;
  logic             carry_d;
  logic [ACC_W-1:0] acc_add_d;
  logic [ACC_W-1:0] acc_first_d;
  logic [CNT_W-1:0] count_inc_d;
  logic             run_end_d;

  assign xfer_d      = bus.in_valid && in_ready_q;
  assign acc_first_d = {{(ACC_W-PROD_W){1'b0}}, bus.in_product};
  assign sum_d       = {1'b0, acc_q} + {1'b0, acc_first_d};
  assign carry_d     = sum_d[ACC_W];
  assign count_inc_d = count_q + CNT_W'(1);
  // A run ends on an explicit last term or when the forced length is reached.
  assign run_end_d   = bus.in_last || (count_inc_d == CNT_W'(MAX_TERMS));

`ifdef SATURATE_EN
  // Once the run has overflowed, the sum is pinned at full scale.
  assign acc_add_d = (carry_d || ovf_q) ? ACC_MAX : sum_d[ACC_W-1:0];
`else
  assign acc_add_d = sum_d[ACC_W-1:0];
`endif

  // Control FSM with registered handshake outputs and accumulator datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      // Abort wins over any transfer; a pending result is simply dropped.
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      if (state_q != S_HOLD) begin
        acc_q   <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (xfer_d) begin
            acc_q   <= acc_first_d;
            count_q <= CNT_W'(1);
            ovf_q   <= 1'b0;
            if (bus.in_last || (MAX_TERMS == 1)) begin
              state_q     <= S_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (xfer_d) begin
            acc_q   <= acc_add_d;
            count_q <= count_inc_d;
            ovf_q   <= ovf_q | carry_d;
            if (run_end_d) begin
              state_q     <= S_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_acc      = acc_q;
  assign bus.out_count    = count_q;
  assign bus.out_overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_accumulator.sv
// ============================================================================
//  Module   : tb_mult_accumulator
//  Purpose  : Scoreboard bench for mult_accumulator. Instance 0 uses default
//             widths; instance 1 uses ACC_W=33 for overflow behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  mult_accumulator_if #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) bus0 ();
  mult_accumulator_if #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) bus1 ();

  mult_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(8), .MAX_TERMS(255)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus0.slave)
  );

  mult_accumulator #(.PROD_W(32), .ACC_W(33), .CNT_W(8), .MAX_TERMS(255)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus1.slave)
  );

  typedef struct {
    logic [39:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [39:0] a, input logic [7:0] c, input logic o);
    exp_t e;
    e.acc = a;
    e.cnt = c;
    e.ovf = o;
    return e;
  endfunction

  // Scoreboard monitor, default-width instance.
  always @(negedge clk) begin
    if (!rst && bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL res0_unexpected: got result acc=0x%0h, expected none", bus0.out_acc);
      end else begin
        e0 = q0.pop_front();
        chk("res0_acc", 64'(bus0.out_acc), 64'(e0.acc));
        chk("res0_count", 64'(bus0.out_count), 64'(e0.cnt));
        chk("res0_ovf", 64'(bus0.out_overflow), 64'(e0.ovf));
      end
    end
  end

  // Scoreboard monitor, 33-bit instance.
  always @(negedge clk) begin
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL res1_unexpected: got result acc=0x%0h, expected none", bus1.out_acc);
      end else begin
        e1 = q1.pop_front();
        chk("res1_acc", 64'(bus1.out_acc), 64'(e1.acc[32:0]));
        chk("res1_count", 64'(bus1.out_count), 64'(e1.cnt));
        chk("res1_ovf", 64'(bus1.out_overflow), 64'(e1.ovf));
      end
    end
  end

  // Offer one product to the selected instance and hold it until accepted.
  task automatic send(input bit sel, input logic [31:0] p, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    if (!sel) begin
      bus0.in_valid = 1'b1; bus0.in_product = p; bus0.in_last = last;
    end else begin
      bus1.in_valid = 1'b1; bus1.in_product = p; bus1.in_last = last;
    end
    while (!(sel ? bus1.in_ready : bus0.in_ready)) begin
      n++;
      if (n > 1000) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", n);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    bus0.in_last  = 1'b0;
    bus1.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
  endtask

  initial begin
    bus0.in_valid = 1'b0; bus0.in_product = '0; bus0.in_last = 1'b0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_product = '0; bus1.in_last = 1'b0; bus1.out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_in_ready", 64'(bus0.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_out_acc", 64'(bus0.out_acc), 64'd0);
    chk("rst_out_count", 64'(bus0.out_count), 64'd0);
    chk("rst_out_ovf", 64'(bus0.out_overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus0.in_ready), 64'd1);

    // Single term
    q0.push_back(mk(40'd6, 8'd1, 1'b0));
    send(1'b0, 32'h0000_0006, 1'b1);
    @(negedge clk);
    chk("single_out_valid", 64'(bus0.out_valid), 64'd1);
    chk("single_in_ready_hold", 64'(bus0.in_ready), 64'd0);
    @(negedge clk);
    chk("single_back_idle", 64'(bus0.in_ready), 64'd1);
    chk("single_valid_drop", 64'(bus0.out_valid), 64'd0);
    drain();

    // Three-term run with delayed consumer
    bus0.out_ready = 1'b0;
    q0.push_back(mk(40'h02_0000_0000, 8'd3, 1'b0));
    send(1'b0, 32'hFFFF_FFFF, 1'b0);
    send(1'b0, 32'hFFFF_FFFF, 1'b0);
    send(1'b0, 32'h0000_0002, 1'b1);
    repeat (3) @(negedge clk);
    chk("three_in_ready_stall", 64'(bus0.in_ready), 64'd0);
    chk("three_out_valid", 64'(bus0.out_valid), 64'd1);
    bus0.out_ready = 1'b1;
    drain();

    // Forced end after MAX_TERMS transfers
    bus0.out_ready = 1'b0;
    q0.push_back(mk(40'd255, 8'd255, 1'b0));
    for (int i = 0; i < 255; i++) send(1'b0, 32'd1, 1'b0);
    @(negedge clk);
    bus0.in_valid = 1'b1; bus0.in_product = 32'd1;
    repeat (3) @(negedge clk);
    chk("forced_256th_stall", 64'(bus0.in_ready), 64'd0);
    chk("forced_out_valid", 64'(bus0.out_valid), 64'd1);
    chk("forced_count", 64'(bus0.out_count), 64'd255);
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b1;
    drain();

    // Overflow on the 33-bit instance
    q1.push_back(mk(40'h1_FFFF_FFFE, 8'd2, 1'b0));
    send(1'b1, 32'hFFFF_FFFF, 1'b0);
    send(1'b1, 32'hFFFF_FFFF, 1'b1);
    drain();
`ifdef SATURATE_EN
    q1.push_back(mk(40'h1_FFFF_FFFF, 8'd3, 1'b1));
`else
    q1.push_back(mk(40'h0_0000_0000, 8'd3, 1'b1));
`endif
    send(1'b1, 32'hFFFF_FFFF, 1'b0);
    send(1'b1, 32'hFFFF_FFFF, 1'b0);
    send(1'b1, 32'h0000_0002, 1'b1);
    drain();

    // Abort mid-run; the product offered with clr must not be taken
    send(1'b0, 32'd5, 1'b0);
    send(1'b0, 32'd7, 1'b0);
    @(negedge clk);
    clr = 1'b1; bus0.in_valid = 1'b1; bus0.in_product = 32'd9;
    @(posedge clk);
    #1;
    clr = 1'b0; bus0.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_in_ready", 64'(bus0.in_ready), 64'd1);
    chk("clr_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("clr_acc_zero", 64'(bus0.out_acc), 64'd0);
    chk("clr_count_zero", 64'(bus0.out_count), 64'd0);
    q0.push_back(mk(40'd3, 8'd1, 1'b0));
    send(1'b0, 32'd3, 1'b1);
    drain();

    // Asynchronous reset while holding a result
    bus0.out_ready = 1'b0;
    send(1'b0, 32'h10, 1'b1);
    @(negedge clk);
    chk("hold_before_rst", 64'(bus0.out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus0.out_valid), 64'd0);
    chk("async_rst_acc", 64'(bus0.out_acc), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    chk("async_rst_in_ready", 64'(bus0.in_ready), 64'd1);
    chk("async_rst_no_result", 64'(bus0.out_valid), 64'd0);

    repeat (2) @(negedge clk);
    chk("final_q0_empty", 64'(q0.size()), 64'd0);
    chk("final_q1_empty", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
